// File: rtl/pong_pkg.sv
// Shared state encoding, ball geometry and edge-detect helper for the Motion Pong datapath.
package pong_pkg;
  typedef enum logic [2:0] {IDLE, DRAW, WAIT, ERASE, MOVE} state_e;

  localparam int         BALL_SIZE    = 4;
  localparam logic [7:0] RESET_X      = 8'd78;
  localparam logic [6:0] RESET_Y      = 7'd58;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  // True when the next step along this axis would leave [0, hi].
  function automatic logic at_edge(input logic [7:0] pos, input logic neg, input logic [7:0] hi);
    return neg ? (pos == 8'd0) : (pos == hi);
  endfunction
endpackage

// File: rtl/frame_tick.sv
// Loadable down-counter that paces one frame; holds at zero until reloaded.
module frame_tick #(
  parameter int TICK_CYCLES = 833333
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  input  logic en,
  output logic zero
);
  localparam int            CW     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = RELOAD;
    else if (en && cnt_q != '0)  cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!resetn) cnt_q <= RELOAD;
    else         cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/ball_motion_controller.sv
// Ball owner: per frame erases the 4x4 ball, steps/bounces it, redraws it, one pixel per cycle.
module ball_motion_controller
  import pong_pkg::*;
#(
  parameter int         TICK_CYCLES = 833333,
  parameter int         X_MAX       = 159,
  parameter int         Y_MAX       = 119,
  parameter logic [2:0] BALL_COLOUR = 3'b111
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic [7:0] ball_x,
  output logic [6:0] ball_y,
  output logic       hit_left,
  output logic       hit_right
);
  localparam logic [3:0] LAST_PIX = 4'(BALL_SIZE * BALL_SIZE - 1);
  localparam logic [7:0] X_HI     = 8'(X_MAX - (BALL_SIZE - 1));
  localparam logic [7:0] Y_HI     = 8'(Y_MAX - (BALL_SIZE - 1));

  state_e     state_q, state_d;
  logic [3:0] pix_cnt_q, pix_cnt_d;
  logic [7:0] ball_x_q, ball_x_d;
  logic [6:0] ball_y_q, ball_y_d;
  logic       dx_neg_q, dx_neg_d;
  logic       dy_neg_q, dy_neg_d;
  logic [7:0] x_out_q, x_out_d;
  logic [6:0] y_out_q, y_out_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       hit_left_q, hit_left_d;
  logic       hit_right_q, hit_right_d;
  logic       tick_load, tick_en, tick_zero;
  logic       bounce_x, bounce_y;

  frame_tick #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clock  (clock),
    .resetn (resetn),
    .load   (tick_load),
    .en     (tick_en),
    .zero   (tick_zero)
  );

  always_comb begin
    bounce_x    = at_edge(ball_x_q, dx_neg_q, X_HI);
    bounce_y    = at_edge({1'b0, ball_y_q}, dy_neg_q, Y_HI);
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    colour_d    = colour_q;
    plot_d      = 1'b0;
    hit_left_d  = 1'b0;
    hit_right_d = 1'b0;
    tick_load   = 1'b0;
    tick_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = DRAW;
          pix_cnt_d = 4'd0;
        end
      end
      DRAW, ERASE: begin
        // Bursts run to completion regardless of enable.
        plot_d    = 1'b1;
        colour_d  = (state_q == DRAW) ? BALL_COLOUR : COLOUR_BLACK;
        x_out_d   = ball_x_q + {6'd0, pix_cnt_q[1:0]};
        y_out_d   = ball_y_q + {5'd0, pix_cnt_q[3:2]};
        pix_cnt_d = pix_cnt_q + 4'd1;
        if (pix_cnt_q == LAST_PIX) state_d = (state_q == DRAW) ? WAIT : MOVE;
      end
      WAIT: begin
        if (enable) begin
          if (tick_zero) begin
            tick_load = 1'b1;
            state_d   = ERASE;
            pix_cnt_d = 4'd0;
          end else begin
            tick_en = 1'b1;
          end
        end
      end
      MOVE: begin
        // A bounce flips direction first, so the step lands one pixel back inside.
        dx_neg_d    = dx_neg_q ^ bounce_x;
        dy_neg_d    = dy_neg_q ^ bounce_y;
        ball_x_d    = dx_neg_d ? ball_x_q - 8'd1 : ball_x_q + 8'd1;
        ball_y_d    = dy_neg_d ? ball_y_q - 7'd1 : ball_y_q + 7'd1;
        hit_left_d  = bounce_x & dx_neg_q;
        hit_right_d = bounce_x & ~dx_neg_q;
        state_d     = DRAW;
        pix_cnt_d   = 4'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      pix_cnt_q   <= 4'd0;
      ball_x_q    <= RESET_X;
      ball_y_q    <= RESET_Y;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      x_out_q     <= 8'd0;
      y_out_q     <= 7'd0;
      colour_q    <= COLOUR_BLACK;
      plot_q      <= 1'b0;
      hit_left_q  <= 1'b0;
      hit_right_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      colour_q    <= colour_d;
      plot_q      <= plot_d;
      hit_left_q  <= hit_left_d;
      hit_right_q <= hit_right_d;
    end
  end

  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_q;
  assign plot       = plot_q;
  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign hit_left   = hit_left_q;
  assign hit_right  = hit_right_q;
endmodule

// File: tb/tb_ball_motion_controller.sv
// Bench: per-cycle output stream predicted from frame-level rules with a closed-form bounce path.
module tb_ball_motion_controller;
  localparam int TICK = 4, XM = 187, YM = 119;
  localparam int RX = XM - 3, RY = YM - 3;
  localparam int K_IDLE = 0, K_DRAW = 1, K_WAIT = 2, K_ERASE = 3, K_MOVE = 4;

  logic       clock = 1'b0, resetn = 1'b0, enable = 1'b0;
  logic [7:0] x_out, ball_x;
  logic [6:0] y_out, ball_y;
  logic [2:0] colour_out;
  logic       plot, hit_left, hit_right;
  int         checks = 0, errors = 0;

  always #5 clock = ~clock;

  ball_motion_controller #(.TICK_CYCLES(TICK), .X_MAX(XM), .Y_MAX(YM), .BALL_COLOUR(3'b111)) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot),
    .ball_x(ball_x), .ball_y(ball_y), .hit_left(hit_left), .hit_right(hit_right)
  );

  // One entry per clock edge: what the outputs show after that edge.
  // Gated entries (IDLE, WAIT) only advance on an edge where enable is high.
  typedef struct {
    int kind, idx, mv;
    bit gated, plot, hl, hr;
    int x, y, c, bx, by;
  } item_t;

  item_t q[$];
  int    moves_gen = 0, moves_done = 0;
  bit    started = 0;
  int    last_x = 0, last_y = 0, last_c = 0, last_bx = 78, last_by = 58;

  // Ball path unfolded onto a line of period 2r, folded back into [0, r].
  function automatic int fold(int start, int n, int r);
    int u;
    u = (start + n) % (2 * r);
    return (u <= r) ? u : 2 * r - u;
  endfunction

  function automatic logic [35:0] pack(int p, int x, int y, int c, int bx, int by, int hl, int hr);
    logic [35:0] v;
    v = {p[0], x[7:0], y[6:0], c[2:0], bx[7:0], by[6:0], hl[0], hr[0]};
    return v;
  endfunction

  task automatic chk(string name, logic [35:0] got, logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_item(int kind, int idx, int mv, bit gated, bit p, int x, int y, int c,
                           int bx, int by, bit hl, bit hr);
    item_t it;
    it.kind = kind; it.idx = idx; it.mv = mv; it.gated = gated; it.plot = p;
    it.x = x; it.y = y; it.c = c; it.bx = bx; it.by = by; it.hl = hl; it.hr = hr;
    q.push_back(it);
  endtask

  task automatic push_burst(int kind, int bx, int by, int c);
    for (int k = 0; k < 16; k++)
      push_item(kind, k, -1, 1'b0, 1'b1, bx + k % 4, by + k / 4, c, bx, by, 1'b0, 1'b0);
  endtask

  task automatic push_waits(int bx, int by);
    for (int k = 0; k < TICK; k++)
      push_item(K_WAIT, k, -1, 1'b1, 1'b0, 0, 0, 0, bx, by, 1'b0, 1'b0);
  endtask

  task automatic gen_frame(int m);
    int bx0, by0, bx1, by1, u;
    bx0 = fold(78, m, RX);     by0 = fold(58, m, RY);
    bx1 = fold(78, m + 1, RX); by1 = fold(58, m + 1, RY);
    u   = (78 + m) % (2 * RX);
    push_burst(K_ERASE, bx0, by0, 0);
    push_item(K_MOVE, 0, m, 1'b0, 1'b0, 0, 0, 0, bx1, by1, u == 0, u == RX);
    push_burst(K_DRAW, bx1, by1, 7);
    push_waits(bx1, by1);
  endtask

  task automatic refill();
    if (!started) begin
      started = 1;
      push_item(K_IDLE, 0, -1, 1'b1, 1'b0, 0, 0, 0, 78, 58, 1'b0, 1'b0);
      push_burst(K_DRAW, 78, 58, 7);
      push_waits(78, 58);
    end
    while (q.size() < 40) begin
      gen_frame(moves_gen);
      moves_gen++;
    end
  endtask

  initial begin : compare_proc
    item_t       it;
    logic [35:0] exp, got;
    bit          en, rn;
    forever begin
      @(posedge clock);
      rn = resetn; en = enable;
      it.kind = -1; it.mv = -1;
      if (!rn) begin
        q.delete(); started = 0; moves_gen = 0;
        last_x = 0; last_y = 0; last_c = 0; last_bx = 78; last_by = 58;
        exp = pack(0, 0, 0, 0, 78, 58, 0, 0);
      end else begin
        refill();
        if (q[0].gated && !en) begin
          exp = pack(0, last_x, last_y, last_c, last_bx, last_by, 0, 0);
        end else begin
          it = q.pop_front();
          if (it.plot) begin last_x = it.x; last_y = it.y; last_c = it.c; end
          last_bx = it.bx; last_by = it.by;
          exp = pack(it.plot, last_x, last_y, last_c, last_bx, last_by, it.hl, it.hr);
          if (it.kind == K_MOVE) moves_done++;
        end
      end
      #1;
      got = {plot, x_out, y_out, colour_out, ball_x, ball_y, hit_left, hit_right};
      chk("cycle", got, exp);
      if (it.kind == K_MOVE && it.mv == 106)
        chk("bounce_right", {ball_x, hit_right, hit_left}, {8'd183, 1'b1, 1'b0});
      if (it.kind == K_MOVE && it.mv == 290)
        chk("corner_left_bottom", {ball_x, ball_y, hit_left, hit_right}, {8'd1, 7'd115, 1'b1, 1'b0});
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin : stim
    int cyc;
    resetn = 0; enable = 0;
    tick(3);
    chk("reset_outputs", {plot, x_out, y_out, colour_out, hit_left, hit_right}, 36'd0);
    chk("reset_ball", {ball_x, ball_y}, {8'd78, 7'd58});

    @(negedge clock); resetn = 1; enable = 1;
    tick(2);
    chk("draw_first_pixel", {plot, x_out, y_out, colour_out}, {1'b1, 8'd78, 7'd58, 3'd7});
    tick(15);
    chk("draw_last_pixel", {plot, x_out, y_out, colour_out}, {1'b1, 8'd81, 7'd61, 3'd7});
    tick(1);
    chk("wait_no_plot", {plot, x_out}, {1'b0, 8'd81});
    tick(4);
    chk("erase_first_pixel", {plot, x_out, y_out, colour_out}, {1'b1, 8'd78, 7'd58, 3'd0});
    tick(16);
    chk("move_result", {plot, ball_x, ball_y, hit_left, hit_right}, {1'b0, 8'd79, 7'd59, 2'b00});
    tick(1);
    chk("redraw_first_pixel", {plot, x_out, y_out, colour_out}, {1'b1, 8'd79, 7'd59, 3'd7});

    // Drop enable while the draw burst is at pixel 5.
    tick(4);
    @(negedge clock); enable = 0;
    tick(11);
    chk("burst_completes", {plot, x_out, y_out}, {1'b1, 8'd82, 7'd62});
    tick(20);
    chk("wait_frozen", {plot, colour_out}, {1'b0, 3'd7});
    @(negedge clock); enable = 1;

    cyc = 0;
    while (moves_done < 292 && cyc < 40000) begin
      @(negedge clock);
      enable = ($urandom_range(0, 7) != 0);
      cyc++;
    end
    if (moves_done < 292) begin
      checks++; errors++;
      $display("FAIL progress: moves %0d expected 292", moves_done);
    end

    @(negedge clock); enable = 1;
    cyc = 0;
    while (!(q.size() > 0 && q[0].kind == K_ERASE && q[0].idx == 7) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 200) begin
      checks++; errors++;
      $display("FAIL erase_search: cycles %0d limit 200", cyc);
    end
    resetn = 0;
    tick(1);
    chk("reset_mid_erase", {plot, ball_x, ball_y, hit_left, hit_right}, {1'b0, 8'd78, 7'd58, 2'b00});
    tick(2);
    @(negedge clock); resetn = 1;
    tick(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
